// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants, sample type, FSM states and saturating add
// Contents:
//   AUDIO_DATA_W   sample width used across the audio path
//   AUDIO_FS_HZ    nominal sample rate of the codec side
//   audio_sample_t signed sample type
//   echo_state_t   audio_echo FSM states
//   sat_add        two's complement add clipped to the sample range
package audio_pkg;

    localparam int AUDIO_DATA_W = 24;
    localparam int AUDIO_FS_HZ  = 48000;

    typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MIX_L,
        ST_MIX_R,
        ST_WR,
        ST_OUT
    } echo_state_t;

    // One guard bit is enough to detect overflow of a two-operand add; when the
    // two top bits disagree the true result lies outside the sample range.
    function automatic audio_sample_t sat_add(input audio_sample_t a, input audio_sample_t b);
        logic [AUDIO_DATA_W:0] sum;
        sum = {a[AUDIO_DATA_W-1], a} + {b[AUDIO_DATA_W-1], b};
        if (sum[AUDIO_DATA_W] != sum[AUDIO_DATA_W-1])
            sat_add = sum[AUDIO_DATA_W] ? {1'b1, {(AUDIO_DATA_W-1){1'b0}}}
                                        : {1'b0, {(AUDIO_DATA_W-1){1'b1}}};
        else
            sat_add = sum[AUDIO_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/audio_delay_ram.sv
// rtl/audio_delay_ram.sv - simple-dual-port RAM with registered (1-cycle) read
// Ports:
//   clk      clock
//   i_we     write enable, i_waddr/i_wdata write address/data
//   i_re     read enable, i_raddr read address
//   o_rdata  read data, valid the cycle after i_re, held otherwise
module audio_delay_ram #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 48
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    // No reset: contents are masked by the fill count in audio_echo.
    logic [WORD_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/audio_echo.sv
// rtl/audio_echo.sv - stereo feedback echo: out = in + (out delayed by delay_len) >>> FB_SHIFT
// Ports:
//   clk_100, reset        clock, synchronous active-high reset
//   in_l, in_r, in_valid  input sample pair and its one-cycle strobe
//   delay_len, bypass     echo delay in samples and pass-through, taken with in_valid
//   out_l, out_r          output pair, held until the next update
//   out_valid             one-cycle strobe, six cycles after the accepted in_valid
//   busy                  high while a sample is being processed
//   overrun               sticky, set when in_valid arrives while busy
module audio_echo
    import audio_pkg::*;
#(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int ADDR_W   = 12,
    parameter int FB_SHIFT = 1
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_l,
    input  logic [DATA_W-1:0] in_r,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic              bypass,
    output logic [DATA_W-1:0] out_l,
    output logic [DATA_W-1:0] out_r,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

    echo_state_t r_state, w_next_state;

    logic [DATA_W-1:0] r_in_l, r_in_r, r_res_l, r_res_r;
    logic [ADDR_W-1:0] r_delay, r_wr_ptr;
    logic [ADDR_W:0]   r_fill_cnt;
    logic              r_bypass;

    logic                     w_ram_re, w_ram_we;
    logic [ADDR_W-1:0]        w_raddr;
    logic [2*DATA_W-1:0]      w_rdata;
    logic                     w_use_echo;
    logic signed [DATA_W-1:0] w_mix_in, w_mix_dly, w_wet, w_sat, w_result;
    logic signed [DATA_W:0]   w_sum;

    audio_delay_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (2*DATA_W)
    ) u_ram (
        .clk     (clk_100),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({r_res_l, r_res_r}),
        .i_re    (w_ram_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Unsigned subtraction in ADDR_W bits gives the circular wrap for free.
    assign w_raddr = r_wr_ptr - r_delay;
    assign busy    = (r_state != ST_IDLE);

    // Only echo once the buffer holds at least delay_len samples written since reset.
    assign w_use_echo = (r_delay != '0) && (r_fill_cnt >= {1'b0, r_delay});

    always_ff @(posedge clk_100) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_ram_re     = 1'b0;
        w_ram_we     = 1'b0;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next_state = ST_RD;
            ST_RD: begin
                w_ram_re     = 1'b1;
                w_next_state = ST_MIX_L;
            end
            ST_MIX_L: w_next_state = ST_MIX_R;
            ST_MIX_R: w_next_state = ST_WR;
            ST_WR: begin
                w_ram_we     = 1'b1;
                w_next_state = ST_OUT;
            end
            ST_OUT:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Single adder/saturator shared by both channels; MIX_L selects left, MIX_R right.
    always_comb begin
        w_mix_in  = (r_state == ST_MIX_L) ? r_in_l : r_in_r;
        w_mix_dly = '0;
        if (w_use_echo)
            w_mix_dly = (r_state == ST_MIX_L) ? w_rdata[2*DATA_W-1:DATA_W] : w_rdata[DATA_W-1:0];
        w_wet = w_mix_dly >>> FB_SHIFT;
        w_sum = {w_mix_in[DATA_W-1], w_mix_in} + {w_wet[DATA_W-1], w_wet};
        if (w_sum[DATA_W] != w_sum[DATA_W-1])
            w_sat = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            w_sat = w_sum[DATA_W-1:0];
        w_result = r_bypass ? w_mix_in : w_sat;
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            out_l      <= '0;
            out_r      <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && r_state != ST_IDLE)
                overrun <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_in_l   <= in_l;
                        r_in_r   <= in_r;
                        r_delay  <= delay_len;
                        r_bypass <= bypass;
                    end
                end
                ST_MIX_L: r_res_l <= w_result;
                ST_MIX_R: r_res_r <= w_result;
                ST_WR: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_fill_cnt != FILL_MAX)
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                ST_OUT: begin
                    out_l     <= r_res_l;
                    out_r     <= r_res_r;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_echo.sv
// tb/tb_audio_echo.sv - directed self-checking bench for audio_echo (12-bit and 4-bit address builds)
module tb_audio_echo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [23:0] a_in_l = '0, a_in_r = '0;
    logic        a_in_valid = 1'b0, a_bypass = 1'b0;
    logic [11:0] a_delay = '0;
    logic [23:0] a_out_l, a_out_r;
    logic        a_out_valid, a_busy, a_overrun;

    logic [23:0] b_in_l = '0, b_in_r = '0;
    logic        b_in_valid = 1'b0, b_bypass = 1'b0;
    logic [3:0]  b_delay = '0;
    logic [23:0] b_out_l, b_out_r;
    logic        b_out_valid, b_busy, b_overrun;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    audio_echo #(.DATA_W(24), .ADDR_W(12), .FB_SHIFT(1)) u_dut_a (
        .clk_100(clk), .reset(reset),
        .in_l(a_in_l), .in_r(a_in_r), .in_valid(a_in_valid),
        .delay_len(a_delay), .bypass(a_bypass),
        .out_l(a_out_l), .out_r(a_out_r), .out_valid(a_out_valid),
        .busy(a_busy), .overrun(a_overrun)
    );

    audio_echo #(.DATA_W(24), .ADDR_W(4), .FB_SHIFT(1)) u_dut_b (
        .clk_100(clk), .reset(reset),
        .in_l(b_in_l), .in_r(b_in_r), .in_valid(b_in_valid),
        .delay_len(b_delay), .bypass(b_bypass),
        .out_l(b_out_l), .out_r(b_out_r), .out_valid(b_out_valid),
        .busy(b_busy), .overrun(b_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drives one sample into DUT a (sel=0) or b (sel=1) and waits for out_valid.
    // lat counts rising edges from the one that accepts in_valid to out_valid.
    task automatic send(input bit sel, input logic [23:0] l, input logic [23:0] r,
                        input logic [11:0] d, input bit byp,
                        output logic [23:0] ol, output logic [23:0] orr, output int lat);
        @(posedge clk); #1;
        if (!sel) begin
            a_in_l = l; a_in_r = r; a_delay = d; a_bypass = byp; a_in_valid = 1'b1;
        end else begin
            b_in_l = l; b_in_r = r; b_delay = d[3:0]; b_bypass = byp; b_in_valid = 1'b1;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        lat = 1;
        while (!(sel ? b_out_valid : a_out_valid) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 20) check("timeout", 32'(lat), 32'd6);
        ol  = sel ? b_out_l : a_out_l;
        orr = sel ? b_out_r : a_out_r;
    endtask

    logic [23:0] ol, orr;
    int          lat;
    int          cnt;
    int          y [40];
    logic [23:0] imp_exp [12];

    initial begin
        do_reset();

        // Reset state
        check("rst_out_l", a_out_l, 0);
        check("rst_out_r", a_out_r, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_overrun", a_overrun, 0);

        // First sample after reset: no echo, latency 6, one-cycle strobe
        send(0, 24'h000100, 24'hFFFF00, 12'd4, 0, ol, orr, lat);
        check("first_l", ol, 24'h000100);
        check("first_r", orr, 24'hFFFF00);
        check("first_lat", lat, 6);
        @(posedge clk); #1;
        check("first_strobe_len", a_out_valid, 0);
        check("first_busy_after", a_busy, 0);

        // Impulse, delay 3, feedback halves each repeat
        do_reset();
        for (int i = 0; i < 12; i++) imp_exp[i] = 24'h0;
        imp_exp[0] = 24'h100000; imp_exp[3] = 24'h080000;
        imp_exp[6] = 24'h040000; imp_exp[9] = 24'h020000;
        for (int i = 0; i < 12; i++) begin
            send(0, (i == 0) ? 24'h100000 : 24'h0, 24'h0, 12'd3, 0, ol, orr, lat);
            check($sformatf("imp_l[%0d]", i), ol, imp_exp[i]);
            check($sformatf("imp_r[%0d]", i), orr, 0);
        end

        // Saturation: positive clips at 0x7FFFFF, negative at 0x800000
        do_reset();
        send(0, 24'h7FF000, 24'h800000, 12'd1, 0, ol, orr, lat);
        check("sat0_l", ol, 24'h7FF000);
        check("sat0_r", orr, 24'h800000);
        for (int i = 1; i < 5; i++) begin
            send(0, 24'h7FF000, 24'h800000, 12'd1, 0, ol, orr, lat);
            check($sformatf("sat_l[%0d]", i), ol, 24'h7FFFFF);
            check($sformatf("sat_r[%0d]", i), orr, 24'h800000);
        end

        // Wrap-around on the 16-deep build, delay 15, ramp input
        do_reset();
        for (int n = 0; n < 40; n++) begin
            y[n] = n * 256 + ((n >= 15) ? (y[n-15] >>> 1) : 0);
            send(1, 24'(n * 256), 24'h0, 12'd15, 0, ol, orr, lat);
            check($sformatf("wrap_l[%0d]", n), ol, 32'(24'(y[n])));
        end

        // Second in_valid two cycles after the first is dropped
        do_reset();
        @(posedge clk); #1;
        a_in_l = 24'h000111; a_in_r = 24'h0; a_delay = 12'd4; a_bypass = 0; a_in_valid = 1;
        @(posedge clk); #1 a_in_valid = 0;
        @(posedge clk); #1 a_in_l = 24'h222222; a_in_valid = 1;
        @(posedge clk); #1 a_in_valid = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_out_valid) begin
                cnt++;
                check("ovr_out_l", a_out_l, 24'h000111);
            end
            @(posedge clk); #1;
        end
        check("ovr_count", cnt, 1);
        check("ovr_flag", a_overrun, 1);

        // Reset during processing discards the sample
        do_reset();
        @(posedge clk); #1;
        a_in_l = 24'h123456; a_in_r = 24'h654321; a_delay = 12'd4; a_bypass = 0; a_in_valid = 1;
        @(posedge clk); #1 a_in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (a_out_valid) cnt++;
            @(posedge clk); #1;
        end
        check("rmid_count", cnt, 0);
        check("rmid_out_l", a_out_l, 0);
        check("rmid_out_r", a_out_r, 0);
        check("rmid_busy", a_busy, 0);
        check("rmid_overrun", a_overrun, 0);
        send(0, 24'h000100, 24'hFFFF00, 12'd4, 0, ol, orr, lat);
        check("rmid_next_l", ol, 24'h000100);
        check("rmid_next_r", orr, 24'hFFFF00);
        check("rmid_next_lat", lat, 6);

        // Bypass passes input through but still feeds the history
        do_reset();
        send(0, 24'h010000, 24'h0, 12'd2, 0, ol, orr, lat);
        check("byp0", ol, 24'h010000);
        send(0, 24'h000000, 24'h0, 12'd2, 0, ol, orr, lat);
        check("byp1", ol, 24'h000000);
        send(0, 24'h020000, 24'h0, 12'd2, 1, ol, orr, lat);
        check("byp2", ol, 24'h020000);
        send(0, 24'h030000, 24'h0, 12'd2, 1, ol, orr, lat);
        check("byp3", ol, 24'h030000);
        send(0, 24'h000000, 24'h0, 12'd2, 0, ol, orr, lat);
        check("byp4", ol, 24'h010000);
        send(0, 24'h000000, 24'h0, 12'd2, 0, ol, orr, lat);
        check("byp5", ol, 24'h018000);
        send(0, 24'h000000, 24'h0, 12'd2, 0, ol, orr, lat);
        check("byp6", ol, 24'h008000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/audio_echo.md
# audio_echo

Stereo feedback-echo stage between the line-in side and the headphone side of the audio path, in the 100 MHz domain. It consumes the `line_in_l`/`line_in_r`/`new_sample` outputs of the codec interface block and produces `hphone_l`/`hphone_r`/`hphone_l_valid` for it. Each output sample is the input plus an attenuated copy of the output from `delay_len` samples earlier, held in an internal circular buffer.

## Interface
- `DATA_W`, 24: sample width, two's complement.
- `ADDR_W`, 12: buffer address width; depth 2^ADDR_W stereo samples (4096, about 85 ms at 48 kHz).
- `FB_SHIFT`, 1: feedback attenuation; the delayed sample is arithmetically shifted right by FB_SHIFT.

Ports:
- `clk_100` in 1: 100 MHz clock.
- `reset` in 1: synchronous, active-high.
- `in_l` in DATA_W: left input sample, from `line_in_l`.
- `in_r` in DATA_W: right input sample, from `line_in_r`.
- `in_valid` in 1: one-cycle strobe for a new input pair, from `new_sample`.
- `delay_len` in ADDR_W: echo delay in samples; sampled on accepted `in_valid`.
- `bypass` in 1: output equals input; sampled on accepted `in_valid`.
- `out_l` out DATA_W: left output, to `hphone_l`.
- `out_r` out DATA_W: right output, to `hphone_r`.
- `out_valid` out 1: one-cycle strobe, to `hphone_l_valid`.
- `busy` out 1: high while the FSM is not IDLE.
- `overrun` out 1: sticky; set when `in_valid` arrives while busy.

## Operation
- Storage is one inferred simple-dual-port RAM, 2^ADDR_W x 2*DATA_W, word {L,R}. It has a synchronous read with 1-cycle latency.
- State: `wr_ptr` (ADDR_W) and `fill_cnt` (ADDR_W+1, saturates at 2^ADDR_W).
- FSM states are IDLE, RD, MIX_L, MIX_R, WR, OUT.
  - IDLE: on `in_valid`, capture `in_l`, `in_r`, `delay_len` and `bypass`, then go to RD.
  - RD: read address = `wr_ptr - delay_len` mod 2^ADDR_W, with wrap-around. Go to MIX_L.
  - MIX_L: compute the left result, then go to MIX_R.
  - MIX_R: compute the right result, then go to WR. Both mixes share one adder and saturator.
  - WR: write {res_l,res_r} at `wr_ptr`. Increment `wr_ptr` (wraps) and `fill_cnt` (saturating). Go to OUT.
  - OUT: register results to `out_l`/`out_r`, pulse `out_valid`, return to IDLE.
- Mix rule:
  - delayed = RAM data if `delay_len != 0` and `fill_cnt >= delay_len`, otherwise 0. This prevents reading stale or uninitialised RAM.
  - wet = delayed >>> FB_SHIFT.
  - sum = sign-extended in + wet, computed in DATA_W+1 bits.
  - Saturate sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Bypass: result = captured input. The input is still written to the buffer, so history stays continuous.
- `in_valid` while not IDLE: the sample is dropped and `overrun` is set. `overrun` clears only on reset.
- Reset values:
  - outputs: `out_l`=0, `out_r`=0, `out_valid`=0, `busy`=0, `overrun`=0.
  - internal: `wr_ptr`=0, `fill_cnt`=0, FSM=IDLE.
  - RAM contents are not cleared; `fill_cnt` masks them.
- Reset mid-operation: the sample in flight is discarded and no `out_valid` is issued.

## Timing
- `in_valid` is accepted in cycle 0.
- State is RD in cycle 1, MIX_L in 2, MIX_R in 3, WR in 4 and OUT in 5.
- `out_valid` is high in cycle 6, for exactly one cycle. `out_l`/`out_r` are valid from cycle 6 and held until the next update.
- `busy` is high in cycles 1–5.
- A new `in_valid` is accepted from cycle 6 onward. Input spacing is about 2083 cycles, so overrun never occurs in normal use.
- The RAM write in cycle 4 and the read in cycle 1 of the next sample never collide.
- `delay_len` = 2^ADDR_W−1 is the maximum delay.

## Structure
- Shared package `audio_pkg`:
  - constants `AUDIO_DATA_W`=24 and `AUDIO_FS_HZ`=48000;
  - sample typedef `audio_sample_t` (signed [23:0]);
  - saturating-add function `sat_add`.
- One sub-module, `audio_delay_ram`: the parameterised simple-dual-port RAM with sync read. FSM and mix logic stay in `audio_echo`.

## Test plan
- Reset, then one sample with `in_l`=0x000100, `in_r`=0xFFFF00 and `delay_len`=4 → `out_l`/`out_r` equal the inputs, with `out_valid` exactly 6 cycles after `in_valid`.
- Impulse test: `in_l`=0x100000 at sample 0, then zeros, with `delay_len`=3 and FB_SHIFT=1.
  - `out_l` = 0x100000 at sample 0, 0x080000 at sample 3, 0x040000 at sample 6, 0x020000 at sample 9.
  - `out_l` = 0 at all other samples.
- Saturation: constant input 0x7FF000 with `delay_len`=1 → output clips at 0x7FFFFF and never wraps negative. Negative input 0x800000 clips at 0x800000.
- Wrap-around: ADDR_W=4, `delay_len`=15, 40 samples of a ramp → each echo reads the sample from 15 earlier across pointer wrap. No echo before `fill_cnt` reaches 15.
- Second `in_valid` 2 cycles after the first → it is dropped, `overrun`=1, and exactly one `out_valid` is issued.
- Reset asserted in cycle 3 of processing → no `out_valid`, all outputs 0. The next sample behaves as in the first post-reset case, with no echo.
- Bypass=1 with a non-empty buffer → out = in. After bypass drops, echoes of the bypassed samples appear.
